pipe_mux_n: RTL
===============

Name: pipe_mux_n

Overview:
Parametrised N-input, W-bit multiplexer with a registered output stage and valid/ready handshakes on every channel. It generalises the 2:1 16-bit datapath select for pipelined datapaths, e.g. merging register-file, ALU and memory results into the writeback stage.
- Selection is either external (SEL mode) or an internal round-robin arbiter (RR mode).
- Output carries data plus the index of the source channel.

Parameters:
- W, 16, data width per channel.
- N, 4, number of input channels (>=1).
- MODE, 0, 0 = SEL (external select), 1 = RR (round-robin arbitration).
- SW, $clog2(N) (min 1), select/channel-index width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N  per-channel valid.
- in_data  in  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  out  N  per-channel ready.
- sel  in  SW  channel select, used in SEL mode only.
- out_valid  out  1  output register holds data.
- out_data  out  W  registered selected data.
- out_chan  out  SW  index of the channel that produced out_data.
- out_ready  in  1  downstream accept.
- xfer_cnt  out  32  accepted-output count (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_chan=0, xfer_cnt=0.
  - RR pointer resets to N-1, so channel 0 has first priority.
- load = !out_valid || out_ready (single-entry output register; full throughput, no bubble).
- Grant g (combinational, at most one channel):
  - SEL mode: g=sel if sel<N and in_valid[sel]; otherwise no grant. sel>=N never grants and never asserts any in_ready.
  - RR mode: g = first channel with in_valid set, searching from ptr+1 upward modulo N.
- in_ready[i] = load && grant_valid && (i==g). All other in_ready are 0.
  - in_ready must not depend on in_valid of the same channel in SEL mode. The RR dependency is allowed and documented.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge: out_data<=in_data[g], out_chan<=g, out_valid<=1.
- When load && no grant: out_valid<=0 at the edge. out_data and out_chan hold their old values.
- Latency: 1 cycle from input transfer to out_valid. Sustained rate is 1 word/cycle while out_ready=1.
- Backpressure: out_valid=1 && out_ready=0 means all in_ready=0, and out_data/out_chan/out_valid stay stable.
- RR pointer:
  - Updates to g only on an input transfer; it is unchanged on stall or idle.
  - Wrap: g=N-1 → next search starts at 0.
- N=1: SW=1, sel is ignored (always channel 0), RR degenerates to pass-through with a register.
- Reset mid-operation: any held word is discarded. No in_ready asserts while rst_n=0.

Optional Feature:
- Macro PIPE_MUX_XFER_CNT_EN.
- Defined: xfer_cnt increments by 1 on each output transfer (out_valid && out_ready), wraps 2^32-1 → 0, and resets to 0.
- Undefined: xfer_cnt is tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg holds:
  - MODE constants MUX_MODE_SEL=0 and MUX_MODE_RR=1.
  - The clog2-with-min-1 helper function.
- Sub-module rr_arbiter_n contains:
  - Parameter N.
  - Inputs: req[N], advance, clk, rst_n.
  - Outputs: grant index and grant_valid.
  - The pointer register.
- pipe_mux_n instantiates rr_arbiter_n only when MODE=1 (generate).

Test Plan:
1. SEL mode, N=4, W=16:
   - Stimulus: sel=2, in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1.
   - Required: in_ready=4'b0100; next cycle out_valid=1, out_data=BEEF, out_chan=2.
2. Backpressure:
   - Stimulus: out_valid=1 holding 16'h1234, out_ready=0 for 3 cycles while ch0 valid.
   - Required: in_ready=0 throughout and out_data stays 1234. Raising out_ready gives ch0 data on the next cycle with no lost or duplicated word.
3. RR mode, all 4 channels continuously valid with data 16'h000i, out_ready=1:
   - Required: out_chan sequence 0,1,2,3,0,1…, one word per cycle.
4. RR wrap and skip:
   - Stimulus: after a grant to ch3, only ch1 and ch2 valid.
   - Required: ch1 is granted, then ch2.
5. SEL mode, N=3: sel=3 with all in_valid=1:
   - Required: in_ready=0 and out_valid falls to 0 after the held word drains.
6. Reset mid-stream:
   - Stimulus: drop rst_n asynchronously while out_valid=1.
   - Required: out_valid=0 immediately. With PIPE_MUX_XFER_CNT_EN defined, xfer_cnt=0. After release, RR restarts at ch0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipelined mux family.
package pipe_pkg;

   localparam int MUX_MODE_SEL = 0;
   localparam int MUX_MODE_RR  = 1;

   // Index width for n items, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter over N requesters: searches upward from ptr+1 modulo N,
// pointer moves to the granted index only when the caller signals advance.
module rr_arbiter_n
   import pipe_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = clog2_min1(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [SW-1:0] grant,
   output logic          grant_valid
);

   logic [SW-1:0] ptr;
   int            idx;

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!grant_valid && req[idx]) begin
            grant       = SW'(idx);
            grant_valid = 1'b1;
         end
      end
   end

   // Pointer starts at N-1 so channel 0 wins the first arbitration.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= SW'(N - 1);
      else if (advance)
         ptr <= grant;
   end

endmodule

// File: rtl/pipe_mux_n.sv
// N-input W-bit mux with a single-entry registered output and valid/ready on every channel.
// Define PIPE_MUX_XFER_CNT_EN to build the 32-bit accepted-output counter on xfer_cnt.
module pipe_mux_n
   import pipe_pkg::*;
#(
   parameter  int W    = 16,
   parameter  int N    = 4,
   parameter  int MODE = MUX_MODE_SEL,
   localparam int SW   = clog2_min1(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]   in_ready,
   input  logic [SW-1:0]  sel,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_chan,
   input  logic           out_ready,
   output logic [31:0]    xfer_cnt
);

   logic [SW-1:0] grant;
   logic          grant_valid;
   logic          offer;
   logic          load;
   logic          xfer;
   logic [N-1:0]  chan_mask;
   logic [W-1:0]  grant_data;

   assign load = !out_valid || out_ready;
   assign xfer = rst_n && load && grant_valid;

   generate
      if (MODE == MUX_MODE_RR) begin : g_rr
         logic unused_sel;
         assign unused_sel = ^sel;

         rr_arbiter_n #(.N(N)) u_arb (
            .clk        (clk),
            .rst_n      (rst_n),
            .req        (in_valid),
            .advance    (xfer),
            .grant      (grant),
            .grant_valid(grant_valid)
         );
         assign offer = grant_valid;
      end else begin : g_sel
         logic sel_ok;
         if (N == 1) begin : g_one
            logic unused_sel;
            assign unused_sel = ^sel;
            assign sel_ok     = 1'b1;
            assign grant      = '0;
         end else begin : g_many
            assign sel_ok = 32'(sel) < 32'(N);
            assign grant  = sel_ok ? sel : '0;
         end
         // Ready is offered from the select alone so a source never sees its own valid looped back.
         assign offer       = sel_ok;
         assign grant_valid = sel_ok && |(in_valid & chan_mask);
      end
   endgenerate

   always_comb begin
      chan_mask  = '0;
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SW'(i)) begin
            chan_mask[i] = 1'b1;
            grant_data   = in_data[i*W +: W];
         end
      end
   end

   assign in_ready = (rst_n && load && offer) ? chan_mask : '0;

   // NOTE: data and channel registers are reset too; their post-reset zero values are observable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (load) begin
         out_valid <= grant_valid;
         if (grant_valid) begin
            out_data <= grant_data;
            out_chan <= grant;
         end
      end
   end

`ifdef PIPE_MUX_XFER_CNT_EN
   logic [31:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (out_valid && out_ready)
         cnt <= cnt + 32'd1;
   end

   assign xfer_cnt = cnt;
`else
   assign xfer_cnt = '0;
`endif

endmodule
